// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS control path: states, ALU ops,
// opcode/funct values and datapath mux selects.
package mips_defs;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SRCA_W  = 2;
  localparam int unsigned SRCB_W  = 3;
  localparam int unsigned PCSRC_W = 2;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // ALU operation codes, bit-exact with the existing ALU
  localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SRA = 3'b101;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_SRLV = 6'h06;
  localparam logic [OP_W-1:0] FN_SRAV = 6'h07;
  localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
  localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
  localparam logic [OP_W-1:0] FN_AND  = 6'h24;
  localparam logic [OP_W-1:0] FN_OR   = 6'h25;

  localparam logic [SRCA_W-1:0] SRCA_PC   = 2'b00;
  localparam logic [SRCA_W-1:0] SRCA_RS   = 2'b01;
  localparam logic [SRCA_W-1:0] SRCA_RT   = 2'b10;
  localparam logic [SRCA_W-1:0] SRCA_ZERO = 2'b11;

  localparam logic [SRCB_W-1:0] SRCB_RT      = 3'b000;
  localparam logic [SRCB_W-1:0] SRCB_FOUR    = 3'b001;
  localparam logic [SRCB_W-1:0] SRCB_SEXT    = 3'b010;
  localparam logic [SRCB_W-1:0] SRCB_ZEXT    = 3'b011;
  localparam logic [SRCB_W-1:0] SRCB_SEXT_SH = 3'b100;
  localparam logic [SRCB_W-1:0] SRCB_RS      = 3'b101;
  localparam logic [SRCB_W-1:0] SRCB_LUI     = 3'b110;

  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_controller_if.sv
// Control bus between the multi-cycle controller and the MIPS datapath.
interface mc_alu_controller_if
  import mips_defs::*;
#(
  parameter int unsigned CNT_W = 32
);
  logic [OP_W-1:0]    opcode;
  logic [OP_W-1:0]    funct;
  logic               zero;
  logic [ALUOP_W-1:0] ALUOp;
  logic [SRCA_W-1:0]  ALUSrcA;
  logic [SRCB_W-1:0]  ALUSrcB;
  logic               PCWrite;
  logic [PCSRC_W-1:0] PCSrc;
  logic               IorD;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic               RegDst;
  logic               MemtoReg;
  logic               illegal;
  logic [CNT_W-1:0]   instr_cnt;

  modport master (
    input  opcode, funct, zero,
    output ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCSrc, IorD, MemWrite,
           IRWrite, RegWrite, RegDst, MemtoReg, illegal, instr_cnt
  );

  modport slave (
    output opcode, funct, zero,
    input  ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCSrc, IorD, MemWrite,
           IRWrite, RegWrite, RegDst, MemtoReg, illegal, instr_cnt
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational instruction decode: ALU op and operand selects for EXEC,
// branch-target setup otherwise, plus the legality flag.
module alu_op_decode
  import mips_defs::*;
(
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic               is_exec,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [SRCA_W-1:0]  src_a,
  output logic [SRCB_W-1:0]  src_b,
  output logic               legal
);

  logic [ALUOP_W-1:0] ex_op;
  logic [SRCA_W-1:0]  ex_a;
  logic [SRCB_W-1:0]  ex_b;

  // Per-instruction EXEC datapath setup; legal is independent of state
  always_comb begin
    ex_op = ALU_ADD;
    ex_a  = SRCA_RS;
    ex_b  = SRCB_RT;
    legal = 1'b1;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADDU: ex_op = ALU_ADD;
          FN_SUBU: ex_op = ALU_SUB;
          FN_AND:  ex_op = ALU_AND;
          FN_OR:   ex_op = ALU_OR;
          FN_SRLV: begin ex_op = ALU_SRL; ex_a = SRCA_RT; ex_b = SRCB_RS; end
          FN_SRAV: begin ex_op = ALU_SRA; ex_a = SRCA_RT; ex_b = SRCB_RS; end
          default: legal = 1'b0;
        endcase
      end
      OP_ORI:        begin ex_op = ALU_OR;  ex_b = SRCB_ZEXT; end
      OP_LUI:        begin ex_op = ALU_ADD; ex_a = SRCA_ZERO; ex_b = SRCB_LUI; end
      OP_LW, OP_SW:  begin ex_op = ALU_ADD; ex_b = SRCB_SEXT; end
      OP_BEQ:        ex_op = ALU_SUB;
      OP_J:          ;
      default:       legal = 1'b0;
    endcase
  end

  // Outside EXEC the ALU computes PC + (sext(imm)<<2) into ALUOut
  always_comb begin
    alu_op = ALU_ADD;
    src_a  = SRCA_PC;
    src_b  = SRCB_SEXT_SH;
    if (is_exec) begin
      alu_op = ex_op;
      src_a  = ex_a;
      src_b  = ex_b;
    end
  end

endmodule

// File: rtl/mc_alu_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// Moore-decoded datapath controls and a retired-instruction counter.
module mc_alu_controller
  import mips_defs::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mc_alu_controller_if.master  bus
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               retire;
  logic               legal;
  logic [ALUOP_W-1:0] dec_op;
  logic [SRCA_W-1:0]  dec_a;
  logic [SRCB_W-1:0]  dec_b;

  logic [ALUOP_W-1:0] alu_op;
  logic [SRCA_W-1:0]  src_a;
  logic [SRCB_W-1:0]  src_b;
  logic [PCSRC_W-1:0] pc_src;
  logic pc_write, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal;

  alu_op_decode u_dec (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .is_exec (state_q == ST_EXEC),
    .alu_op  (dec_op),
    .src_a   (dec_a),
    .src_b   (dec_b),
    .legal   (legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = ST_FETCH;
    retire     = 1'b0;
    alu_op     = dec_op;
    src_a      = dec_a;
    src_b      = dec_b;
    pc_src     = PCSRC_ALU;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        src_b    = SRCB_FOUR;
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        if (!legal) begin
          illegal = 1'b1;
        end else if (bus.opcode == OP_J) begin
          pc_write = 1'b1;
          pc_src   = PCSRC_JUMP;
          retire   = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (bus.opcode == OP_BEQ) begin
          pc_write = bus.zero;
          pc_src   = PCSRC_ALUOUT;
          retire   = 1'b1;
        end else if (bus.opcode == OP_LW || bus.opcode == OP_SW) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        iord = 1'b1;
        if (bus.opcode == OP_SW) begin
          mem_write = 1'b1;
          retire    = 1'b1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (bus.opcode == OP_RTYPE);
        mem_to_reg = (bus.opcode == OP_LW);
        retire     = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
    // Reset cycle must never commit architectural state
    if (reset) begin
      pc_write  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
    end
  end

  assign bus.ALUOp     = alu_op;
  assign bus.ALUSrcA   = src_a;
  assign bus.ALUSrcB   = src_b;
  assign bus.PCWrite   = pc_write;
  assign bus.PCSrc     = pc_src;
  assign bus.IorD      = iord;
  assign bus.MemWrite  = mem_write;
  assign bus.IRWrite   = ir_write;
  assign bus.RegWrite  = reg_write;
  assign bus.RegDst    = reg_dst;
  assign bus.MemtoReg  = mem_to_reg;
  assign bus.illegal   = illegal;
  assign bus.instr_cnt = cnt_q;

endmodule
